// File: rtl/aes_job_arbiter.sv
// rtl/aes_job_arbiter.sv - round-robin job scheduler in front of a single AES engine
module aes_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*128-1:0]  reqPlaintext,
    input  logic [NREQ*128-1:0]  reqIv,
    input  logic [NREQ*4-1:0]    reqMode,
    output logic [NREQ-1:0]      done,
    output logic [127:0]         respData,
    output logic                 respErr,
    output logic                 busy,
    output logic [2:0]           grantId,
    output logic [127:0]         engPlaintext,
    output logic [127:0]         engIv,
    output logic [7:0]           engCsr,
    input  logic [127:0]         engResult,
    input  logic                 engValid
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_q, grant_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [127:0]    resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            busy_q, busy_d;
    logic [127:0]    plain_q, plain_d;
    logic [127:0]    iv_q, iv_d;
    logic [3:0]      mode_q, mode_d;
    logic            start_q, start_d;

    logic            found;
    logic [2:0]      winner;
    int              idx;
    logic [NREQ-1:0] req_sh;
    logic [NREQ-1:0] owner_onehot;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        req_sh = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx    = (int'(ptr_q) + i) % NREQ;
            req_sh = req >> idx;
            if (!found && req_sh[0]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        wd_d        = wd_q;
        done_d      = '0;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        plain_d     = plain_q;
        iv_d        = iv_q;
        mode_d      = mode_q;
        start_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    plain_d = reqPlaintext[128*int'(winner) +: 128];
                    iv_d    = reqIv[128*int'(winner) +: 128];
                    mode_d  = reqMode[4*int'(winner) +: 4];
                    // An illegal mode never gets a start pulse.
                    start_d = (mode_d[2:0] <= 3'd4);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d = '0;
                if (mode_q[2:0] > 3'd4) begin
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    done_d      = owner_onehot;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result on the timeout cycle takes priority over the abort.
                if (engValid) begin
                    resp_data_d = engResult;
                    resp_err_d  = 1'b0;
                    done_d      = owner_onehot;
                    state_d     = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    done_d      = owner_onehot;
                    state_d     = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                ptr_d       = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
                resp_data_d = '0;
                resp_err_d  = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            wd_q        <= '0;
            done_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            plain_q     <= '0;
            iv_q        <= '0;
            mode_q      <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            wd_q        <= wd_d;
            done_q      <= done_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            busy_q      <= busy_d;
            plain_q     <= plain_d;
            iv_q        <= iv_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
        end
    end

    assign done         = done_q;
    assign respData     = resp_data_q;
    assign respErr      = resp_err_q;
    assign busy         = busy_q;
    assign grantId      = grant_q;
    assign engPlaintext = plain_q;
    assign engIv        = iv_q;
    assign engCsr       = {1'b0, mode_q, start_q, 2'b00};

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb/tb_aes_job_arbiter.sv - directed self-checking bench for aes_job_arbiter
module tb_aes_job_arbiter;

    localparam int NREQ = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*128-1:0] reqPlaintext;
    logic [NREQ*128-1:0] reqIv;
    logic [NREQ*4-1:0] reqMode;
    logic [NREQ-1:0]   done;
    logic [127:0]      respData;
    logic              respErr;
    logic              busy;
    logic [2:0]        grantId;
    logic [127:0]      engPlaintext;
    logic [127:0]      engIv;
    logic [7:0]        engCsr;
    logic [127:0]      engResult;
    logic              engValid;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;
    int done_cnt [NREQ] = '{0, 0, 0, 0};
    int snap [NREQ];
    int s0;
    int g;

    aes_job_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .reqPlaintext (reqPlaintext),
        .reqIv        (reqIv),
        .reqMode      (reqMode),
        .done         (done),
        .respData     (respData),
        .respErr      (respErr),
        .busy         (busy),
        .grantId      (grantId),
        .engPlaintext (engPlaintext),
        .engIv        (engIv),
        .engCsr       (engCsr),
        .engResult    (engResult),
        .engValid     (engValid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (engCsr[2] === 1'b1) start_cnt <= start_cnt + 1;
        for (int b = 0; b < NREQ; b++)
            if (done[b] === 1'b1) done_cnt[b] <= done_cnt[b] + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int maxc);
        for (int k = 0; k < maxc && engCsr[2] !== 1'b1; k++) tick(1);
        chk("start_seen", 128'(engCsr[2]), 128'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},  128'(done),     128'd0);
        chk({tag, "_data"},  respData,       128'd0);
        chk({tag, "_err"},   128'(respErr),  128'd0);
        chk({tag, "_busy"},  128'(busy),     128'd0);
        chk({tag, "_gid"},   128'(grantId),  128'd0);
        chk({tag, "_pt"},    engPlaintext,   128'd0);
        chk({tag, "_iv"},    engIv,          128'd0);
        chk({tag, "_csr"},   128'(engCsr),   128'd0);
    endtask

    initial begin
        reset = 1'b0; req = '0; reqPlaintext = '0; reqIv = '0; reqMode = '0;
        engResult = '0; engValid = 1'b0;
        tick(2);
        chk_all_zero("rst");
        reset = 1'b1;
        tick(1);

        // Single request, result ten cycles after start
        reqPlaintext[127:0] = 128'h3243f6a8885a308d313198a2e0370734;
        reqIv[127:0]        = 128'h000102030405060708090a0b0c0d0e0f;
        req = 4'b0001;
        s0 = start_cnt;
        tick(1);
        chk("s1_csr_start", 128'(engCsr), 128'h04);
        chk("s1_busy", 128'(busy), 128'd1);
        chk("s1_gid", 128'(grantId), 128'd0);
        chk("s1_pt", engPlaintext, 128'h3243f6a8885a308d313198a2e0370734);
        chk("s1_iv", engIv, 128'h000102030405060708090a0b0c0d0e0f);
        tick(1);
        chk("s1_csr_wait", 128'(engCsr), 128'h00);
        tick(9);
        chk("s1_no_early_done", 128'(done), 128'd0);
        engResult = 128'h3925841d02dc09fbdc118597196a0b32;
        engValid  = 1'b1;
        tick(1);
        chk("s1_done", 128'(done), 128'b0001);
        chk("s1_data", respData, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("s1_err", 128'(respErr), 128'd0);
        engValid = 1'b0; req = '0;
        tick(1);
        chk("s1_done_clr", 128'(done), 128'd0);
        chk("s1_idle", 128'(busy), 128'd0);
        chk("s1_one_start", 128'(start_cnt - s0), 128'd1);

        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);

        // Fairness: all four requesters held high for 8 jobs
        for (int i = 0; i < NREQ; i++) begin
            reqPlaintext[128*i +: 128] = 128'h1000 + 128'(i);
            reqIv[128*i +: 128]        = 128'h2000 + 128'(i);
            snap[i] = done_cnt[i];
        end
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            g = j % NREQ;
            wait_start(8);
            chk("fair_gid", 128'(grantId), 128'(g));
            chk("fair_pt", engPlaintext, 128'h1000 + 128'(g));
            tick(1);
            engResult = 128'hA000 + 128'(j);
            engValid  = 1'b1;
            tick(1);
            chk("fair_done", 128'(done), 128'(4'b0001 << g));
            chk("fair_data", respData, 128'hA000 + 128'(j));
            engValid = 1'b0;
            if (j == 7) req = '0;
            tick(1);
        end
        for (int i = 0; i < NREQ; i++)
            chk("fair_count", 128'(done_cnt[i] - snap[i]), 128'd2);

        // Timeout: engine never answers
        req = 4'b0100;
        wait_start(8);
        chk("to_gid", 128'(grantId), 128'd2);
        tick(16);
        chk("to_not_yet", 128'(done), 128'd0);
        tick(1);
        chk("to_done", 128'(done), 128'b0100);
        chk("to_err", 128'(respErr), 128'd1);
        chk("to_data", respData, 128'd0);
        req = '0;
        tick(1);

        // Next job after a timeout proceeds normally
        req = 4'b0001;
        wait_start(8);
        chk("nx_gid", 128'(grantId), 128'd0);
        tick(1);
        engResult = 128'hdeadbeef_00112233_44556677_8899aabb;
        engValid  = 1'b1;
        tick(1);
        chk("nx_done", 128'(done), 128'b0001);
        chk("nx_err", 128'(respErr), 128'd0);
        chk("nx_data", respData, 128'hdeadbeef_00112233_44556677_8899aabb);
        engValid = 1'b0; req = '0;
        tick(1);

        // Stray strobe while idle
        engValid = 1'b1;
        tick(1);
        chk("stray_done_a", 128'(done), 128'd0);
        chk("stray_busy_a", 128'(busy), 128'd0);
        tick(1);
        chk("stray_done_b", 128'(done), 128'd0);
        engValid = 1'b0;

        // Illegal mode 6
        reqMode[7:4] = 4'b0110;
        req = 4'b0010;
        s0 = start_cnt;
        tick(1);
        chk("ill_csr", 128'(engCsr), 128'h30);
        chk("ill_gid", 128'(grantId), 128'd1);
        chk("ill_busy", 128'(busy), 128'd1);
        tick(1);
        chk("ill_done", 128'(done), 128'b0010);
        chk("ill_err", 128'(respErr), 128'd1);
        chk("ill_data", respData, 128'd0);
        req = '0; reqMode = '0;
        tick(1);
        chk("ill_no_start", 128'(start_cnt - s0), 128'd0);

        // Result collides with the timeout cycle
        req = 4'b0100;
        wait_start(8);
        tick(16);
        engResult = 128'hcafef00d_0badc0de_12345678_9abcdef0;
        engValid  = 1'b1;
        tick(1);
        chk("col_done", 128'(done), 128'b0100);
        chk("col_err", 128'(respErr), 128'd0);
        chk("col_data", respData, 128'hcafef00d_0badc0de_12345678_9abcdef0);
        engValid = 1'b0; req = '0;
        tick(1);

        // Reset during WAIT, then ptr restarts at 0
        req = 4'b1100;
        wait_start(8);
        chk("rw_gid", 128'(grantId), 128'd3);
        tick(3);
        reset = 1'b0;
        #2;
        chk_all_zero("rw_async");
        tick(1);
        chk("rw_no_done", 128'(done), 128'd0);
        reset = 1'b1;
        tick(1);
        chk("rw_start", 128'(engCsr[2]), 128'd1);
        chk("rw_gid2", 128'(grantId), 128'd2);
        tick(1);
        engResult = 128'h55;
        engValid  = 1'b1;
        tick(1);
        chk("rw_done", 128'(done), 128'b0100);
        engValid = 1'b0; req = '0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
